// File: rtl/gpr_operand_fetch_if.sv
// gpr_operand_fetch_if: issue, GPR read/write, writeback and operand-buffer signals
interface gpr_operand_fetch_if #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
);
   localparam int ADDR_W = $clog2(NREGS);
   logic              issue_valid, issue_ready, issue_wr;
   logic [ADDR_W-1:0] issue_src1, issue_src2, issue_dest;
   logic [ADDR_W-1:0] read_addr_1, read_addr_2;
   logic [DATA_W-1:0] read_data_1, read_data_2;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic              write_en;
   logic [ADDR_W-1:0] write_dest;
   logic [DATA_W-1:0] write_data;
   logic              op_valid, op_ready, op_wr;
   logic [DATA_W-1:0] op_a, op_b;
   logic [ADDR_W-1:0] op_dest;
   logic [15:0]       hazard_stalls;
   logic              wb_spurious;
   modport master (
      input  issue_valid, issue_src1, issue_src2, issue_dest, issue_wr,
             read_data_1, read_data_2, wb_valid, wb_dest, wb_data, op_ready,
      output issue_ready, read_addr_1, read_addr_2, write_en, write_dest, write_data,
             op_valid, op_a, op_b, op_dest, op_wr, hazard_stalls, wb_spurious
   );
   modport slave (
      output issue_valid, issue_src1, issue_src2, issue_dest, issue_wr,
             read_data_1, read_data_2, wb_valid, wb_dest, wb_data, op_ready,
      input  issue_ready, read_addr_1, read_addr_2, write_en, write_dest, write_data,
             op_valid, op_a, op_b, op_dest, op_wr, hazard_stalls, wb_spurious
   );
endinterface

// File: rtl/gpr_operand_fetch.sv
// gpr_operand_fetch: operand fetch with scoreboard hazard stall, writeback bypass and one-entry output buffer
module gpr_operand_fetch #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input logic clk,
   input logic rst,
   gpr_operand_fetch_if.master bus
);
   localparam int ADDR_W = $clog2(NREGS);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t            r_state, w_state_nxt;
   logic [NREGS-1:0]  r_pending, w_set, w_clr;
   logic [DATA_W-1:0] r_op_a, r_op_b, w_a, w_b;
   logic [ADDR_W-1:0] r_op_dest;
   logic              r_op_wr, r_wb_spurious;
   logic [15:0]       r_stalls;
   logic              w_clr1, w_clr2, w_clrd, w_hazard, w_ready, w_accept;
   assign bus.read_addr_1   = bus.issue_src1;
   assign bus.read_addr_2   = bus.issue_src2;
   assign bus.write_en      = bus.wb_valid;
   assign bus.write_dest    = bus.wb_dest;
   assign bus.write_data    = bus.wb_data;
   assign bus.issue_ready   = w_ready;
   assign bus.op_valid      = r_state == FULL;
   assign bus.op_a          = r_op_a;
   assign bus.op_b          = r_op_b;
   assign bus.op_dest       = r_op_dest;
   assign bus.op_wr         = r_op_wr;
   assign bus.hazard_stalls = r_stalls;
   assign bus.wb_spurious   = r_wb_spurious;
   // A writeback arriving this cycle both clears its hazard and feeds the operand
   always_comb begin
      w_clr1 = bus.wb_valid && bus.wb_dest == bus.issue_src1;
      w_clr2 = bus.wb_valid && bus.wb_dest == bus.issue_src2;
      w_clrd = bus.wb_valid && bus.wb_dest == bus.issue_dest;
      w_hazard = (r_pending[bus.issue_src1] && !w_clr1) ||
                 (r_pending[bus.issue_src2] && !w_clr2) ||
                 (bus.issue_wr && r_pending[bus.issue_dest] && !w_clrd);
      w_ready = !rst && !w_hazard && (r_state == EMPTY || bus.op_ready);
      w_accept = bus.issue_valid && w_ready;
      w_clr = '0;
      w_clr[bus.wb_dest] = bus.wb_valid;
      w_set = '0;
      w_set[bus.issue_dest] = w_accept && bus.issue_wr;
      w_a = w_clr1 ? bus.wb_data : bus.read_data_1;
      w_b = w_clr2 ? bus.wb_data : bus.read_data_2;
      w_state_nxt = w_accept ? FULL : (bus.op_ready ? EMPTY : r_state);
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= EMPTY;
      else r_state <= w_state_nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending     <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_op_dest     <= '0;
         r_op_wr       <= 1'b0;
         r_stalls      <= '0;
         r_wb_spurious <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (w_accept) begin
            r_op_a    <= w_a;
            r_op_b    <= w_b;
            r_op_dest <= bus.issue_dest;
            r_op_wr   <= bus.issue_wr;
         end
         if (bus.issue_valid && w_hazard && r_stalls != 16'hFFFF) r_stalls <= r_stalls + 16'd1;
         r_wb_spurious <= bus.wb_valid && !r_pending[bus.wb_dest];
      end
   end
endmodule

// File: tb/tb_gpr_operand_fetch.sv
// tb_gpr_operand_fetch: directed steps with an operand scoreboard and a GPR model on the DUT ports
module tb_gpr_operand_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  d;
      logic        wr;
   } op_t;
   op_t q[$];
   op_t last;
   logic [15:0] gpr [8] = '{default: 16'h0001};
   always #5 clk = ~clk;
   gpr_operand_fetch_if #(.DATA_W(16), .NREGS(8)) bus ();
   gpr_operand_fetch #(.DATA_W(16), .NREGS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always @(posedge clk) if (bus.write_en) gpr[bus.write_dest] <= bus.write_data;
   assign bus.read_data_1 = gpr[bus.read_addr_1];
   assign bus.read_data_2 = gpr[bus.read_addr_2];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input logic iv, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                      input logic wr, input logic wv, input logic [2:0] wd, input logic [15:0] wdat,
                      input logic opr, input logic exp_rdy);
      logic acc;
      op_t  e;
      bus.issue_valid = iv;
      bus.issue_src1  = s1;
      bus.issue_src2  = s2;
      bus.issue_dest  = d;
      bus.issue_wr    = wr;
      bus.wb_valid    = wv;
      bus.wb_dest     = wd;
      bus.wb_data     = wdat;
      bus.op_ready    = opr;
      #1;
      chk("issue_ready", {31'd0, bus.issue_ready}, {31'd0, exp_rdy});
      acc = iv && bus.issue_ready;
      if (acc) q.push_back(op_t'{(wv && wd == s1) ? wdat : gpr[s1], (wv && wd == s2) ? wdat : gpr[s2], d, wr});
      @(posedge clk);
      #1;
      if (acc) begin
         e = q.pop_front();
         chk("op_valid", {31'd0, bus.op_valid}, 32'd1);
         chk("op_a", {16'd0, bus.op_a}, {16'd0, e.a});
         chk("op_b", {16'd0, bus.op_b}, {16'd0, e.b});
         chk("op_dest", {29'd0, bus.op_dest}, {29'd0, e.d});
         chk("op_wr", {31'd0, bus.op_wr}, {31'd0, e.wr});
         last = e;
      end
   endtask
   initial begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      rst = 1'b0;
      chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
      chk("rst_op_a", {16'd0, bus.op_a}, 32'd0);
      chk("rst_stalls", {16'd0, bus.hazard_stalls}, 32'd0);
      chk("rst_spurious", {31'd0, bus.wb_spurious}, 32'd0);
      chk("rst_pending", {24'd0, dut.r_pending}, 32'd0);
      // plain read with reset-valued GPRs
      cyc(1, 2, 5, 0, 0, 0, 0, 0, 1, 1);
      chk("pending_none", {24'd0, dut.r_pending}, 32'd0);
      // writer of r3 then a stalled reader released by the writeback
      cyc(1, 0, 0, 3, 1, 0, 0, 0, 1, 1);
      chk("pending_r3", {24'd0, dut.r_pending}, 32'h08);
      repeat (4) cyc(1, 3, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("stalls_4", {16'd0, bus.hazard_stalls}, 32'd4);
      cyc(1, 3, 0, 0, 0, 1, 3, 16'hBEEF, 1, 1);
      chk("gpr3", {16'd0, gpr[3]}, 32'hBEEF);
      chk("pending_clr", {24'd0, dut.r_pending}, 32'd0);
      chk("stalls_hold", {16'd0, bus.hazard_stalls}, 32'd4);
      chk("no_spurious", {31'd0, bus.wb_spurious}, 32'd0);
      // spurious writebacks still land in the GPRs
      cyc(0, 0, 0, 0, 0, 1, 6, 16'h1234, 1, 1);
      chk("spurious_r6", {31'd0, bus.wb_spurious}, 32'd1);
      chk("gpr6", {16'd0, gpr[6]}, 32'h1234);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("spurious_end", {31'd0, bus.wb_spurious}, 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 7, 16'h5A5A, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // src1 == src2 both bypassed
      cyc(1, 2, 2, 1, 0, 1, 2, 16'h7777, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // backpressure holds the buffer
      cyc(1, 6, 7, 5, 0, 0, 0, 0, 0, 1);
      cyc(1, 7, 6, 2, 0, 0, 0, 0, 0, 0);
      chk("hold_valid", {31'd0, bus.op_valid}, 32'd1);
      chk("hold_a", {16'd0, bus.op_a}, {16'd0, last.a});
      chk("hold_b", {16'd0, bus.op_b}, {16'd0, last.b});
      chk("hold_dest", {29'd0, bus.op_dest}, {29'd0, last.d});
      cyc(1, 7, 6, 2, 0, 0, 0, 0, 1, 1);
      // same-cycle set and clear of r4: set wins
      cyc(1, 0, 0, 4, 1, 1, 4, 16'h4444, 1, 1);
      chk("pending_r4", {24'd0, dut.r_pending}, 32'h10);
      chk("gpr4", {16'd0, gpr[4]}, 32'h4444);
      cyc(0, 0, 0, 0, 0, 1, 4, 16'h4545, 1, 1);
      chk("r4_wb_not_spurious", {31'd0, bus.wb_spurious}, 32'd0);
      chk("pending_r4_clr", {24'd0, dut.r_pending}, 32'd0);
      // reset with a full buffer and r1/r3 pending
      cyc(1, 0, 0, 1, 1, 0, 0, 0, 1, 1);
      cyc(1, 0, 0, 3, 1, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_pending", {24'd0, dut.r_pending}, 32'h0A);
      chk("pre_rst_valid", {31'd0, bus.op_valid}, 32'd1);
      rst = 1'b1;
      cyc(1, 1, 3, 0, 0, 1, 5, 16'h5555, 1, 0);
      rst = 1'b0;
      chk("rst_wb_gpr5", {16'd0, gpr[5]}, 32'h5555);
      chk("mid_rst_valid", {31'd0, bus.op_valid}, 32'd0);
      chk("mid_rst_pending", {24'd0, dut.r_pending}, 32'd0);
      chk("mid_rst_stalls", {16'd0, bus.hazard_stalls}, 32'd0);
      chk("mid_rst_spurious", {31'd0, bus.wb_spurious}, 32'd0);
      cyc(1, 1, 3, 0, 0, 0, 0, 0, 1, 1);
      chk("scoreboard_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/gpr_operand_fetch.md
# gpr_operand_fetch

Operand-fetch and writeback controller on the initiator side of the `GPRs` read/write ports. It accepts decoded instructions carrying source and destination register numbers and drives the two read addresses. It returns the fetched operands through a one-entry valid/ready output buffer and funnels execution results back into the register write port. A per-register scoreboard stalls issue on RAW/WAW hazards, and same-cycle writeback is bypassed into the operands.

## Interface
- `DATA_W`, 16, register width
- `NREGS`, 8, register count; `ADDR_W` = $clog2(NREGS) = 3
- `clk` input 1 — rising-edge clock
- `rst` input 1 — synchronous reset, active-high
- `issue_valid` input 1 — decoded instruction present
- `issue_ready` output 1 — instruction accepted this cycle when both high
- `issue_src1`, `issue_src2` input ADDR_W — source register numbers
- `issue_dest` input ADDR_W — destination register number
- `issue_wr` input 1 — instruction will later write `issue_dest`
- `read_addr_1`, `read_addr_2` output ADDR_W — to GPRs read ports
- `read_data_1`, `read_data_2` input DATA_W — from GPRs, combinational
- `wb_valid` input 1 — result writeback this cycle (always accepted)
- `wb_dest` input ADDR_W, `wb_data` input DATA_W — writeback target/value
- `write_en` output 1, `write_dest` output ADDR_W, `write_data` output DATA_W — to GPRs write port
- `op_valid` output 1, `op_ready` input 1 — operand buffer handshake
- `op_a`, `op_b` output DATA_W; `op_dest` output ADDR_W; `op_wr` output 1
- `hazard_stalls` output 16 — saturating count of hazard-stalled cycles
- `wb_spurious` output 1 — one-cycle pulse: writeback to a non-pending register

## Operation
- Read addresses: `read_addr_1 = issue_src1`, `read_addr_2 = issue_src2`, combinational, every cycle.
- Write port: `write_en = wb_valid`, `write_dest = wb_dest`, `write_data = wb_data`, combinational pass-through. GPRs commits the write at the same edge.
- Bypass: if `wb_valid` and `wb_dest == issue_srcN`, operand N takes `wb_data`, otherwise `read_data_N`. Applies to each source independently, including src1 == src2.
- Scoreboard: `pending[NREGS-1:0]`.
  - Bit set on accept with `issue_wr`.
  - Bit cleared on `wb_valid` for `wb_dest`.
  - Same-cycle set and clear of the same bit: set wins.
- `clr(r)` means `wb_valid && wb_dest == r`.
- Hazard = (`pending[src1]` && !clr(src1)) || (`pending[src2]` && !clr(src2)) || (`issue_wr` && `pending[dest]` && !clr(dest)).
- Buffer FSM, two states:
  - EMPTY: `op_valid` = 0.
  - FULL: `op_valid` = 1.
- `issue_ready` = !hazard && (EMPTY || `op_ready`). It does not depend on `issue_valid`.
- On accept: load `op_a`, `op_b`, `op_dest`, `op_wr` at the edge; go to (or stay) FULL.
- In FULL with `op_ready` and no accept: go to EMPTY. Outputs hold their last value.
- In FULL with `op_ready` low: `op_*` stable. The buffer does not capture later writebacks; hazard checks guarantee the captured operands are correct.
- `hazard_stalls`: increments when `issue_valid && hazard`; saturates at 16'hFFFF.
- `wb_spurious`: registered; high the cycle after a `wb_valid` with `pending[wb_dest]` = 0. The write is still performed.
- Hazard checks on unused sources are conservative by design; decode substitutes a non-pending register where needed.

## Timing
- Reset values: `pending` = 0, FSM EMPTY, `op_valid` = 0, `op_a` = `op_b` = 0, `op_dest` = 0, `op_wr` = 0, `hazard_stalls` = 0, `wb_spurious` = 0.
- Reset does not touch GPRs contents.
- Reset mid-operation:
  - Scoreboard and in-flight buffer entry are discarded.
  - `issue_ready` is forced 0 during the reset cycle.
  - Writebacks during reset still reach the write port.
- Latency: accepted in cycle N → `op_valid` in N+1.
- Throughput: one instruction per cycle with `op_ready` held high and no hazards.
- Stall release: when the writeback clearing a hazard arrives in cycle N, issue is accepted in N with the bypassed value (zero-bubble).
- Back-to-back dependent pair: an instruction writing r accepted at N stalls a reader of r until r's writeback cycle.

## Test plan
- Reset, then issue src1=2, src2=5, issue_wr=0 with GPRs at reset value 1 → next cycle `op_valid`=1, `op_a`=1, `op_b`=1; `pending`=0.
- Issue dest=3 with issue_wr=1, then a reader of r3 while `wb_valid` is held low for 4 cycles → `issue_ready`=0 for all 4 cycles, `hazard_stalls`=4. Writeback r3=16'hBEEF in cycle 5 → accepted in cycle 5; `op_a`=16'hBEEF next cycle; the GPR holds 16'hBEEF afterwards.
- `op_ready` low with FULL, new `issue_valid` → `issue_ready`=0 and `op_*` unchanged. Raise `op_ready` → accept in the same cycle; new operands appear next cycle.
- Same-cycle events: accept issue_wr for r4 while `wb_valid` targets r4 → write is performed, `pending[4]`=1 afterwards (set wins). A later wb to r4 clears the bit with no `wb_spurious`.
- Writeback to r6 with `pending[6]`=0 → GPR r6 updated, `wb_spurious` pulses exactly one cycle.
- Assert `rst` with FULL and `pending`=8'h0A → next cycle `op_valid`=0, `pending`=0, `hazard_stalls`=0. A prior reader of r1/r3 is accepted immediately.
